// File: rtl/rs_error_values.sv
// rtl/rs_error_values.sv - Forney error-magnitude evaluator for DVB-T RS(204,188), one location per 9 cycles.
// Optional uncorrectable detection (zero divisor, location 8'hFF) under RS_FORNEY_FAIL_EN.
module rs_error_values (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] NumErr,
    input  logic [7:0] Sigma1,
    input  logic [7:0] Sigma2,
    input  logic [7:0] Sigma3,
    input  logic [7:0] Sigma4,
    input  logic [7:0] Sigma5,
    input  logic [7:0] Sigma6,
    input  logic [7:0] Sigma7,
    input  logic [7:0] Sigma8,
    input  logic [7:0] Omega0,
    input  logic [7:0] Omega1,
    input  logic [7:0] Omega2,
    input  logic [7:0] Omega3,
    input  logic [7:0] Omega4,
    input  logic [7:0] Omega5,
    input  logic [7:0] Omega6,
    input  logic [7:0] Omega7,
    input  logic [7:0] Location1,
    input  logic [7:0] Location2,
    input  logic [7:0] Location3,
    input  logic [7:0] Location4,
    input  logic [7:0] Location5,
    input  logic [7:0] Location6,
    input  logic [7:0] Location7,
    input  logic [7:0] Location8,
    output logic [7:0] Value1,
    output logic [7:0] Value2,
    output logic [7:0] Value3,
    output logic [7:0] Value4,
    output logic [7:0] Value5,
    output logic [7:0] Value6,
    output logic [7:0] Value7,
    output logic [7:0] Value8,
    output logic       Busy,
    output logic       Valid,
    output logic       Fail
);

    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

    state_t          state;
    logic [3:0][7:0] sig_odd;
    logic [7:0][7:0] omega;
    logic [7:0][7:0] loc;
    logic [7:0][7:0] val_q;
    logic [3:0]      k;
    logic [3:0]      nc;
    logic [3:0]      nc_in;
    logic [2:0]      t;
    logic [7:0]      num;
    logic [7:0]      den;
    logic [7:0]      alog_rom [256];
    logic [7:0]      log_rom [256];
    logic [7:0]      j_k;
    logic [7:0]      inv;
    logic [7:0]      omega_t;
    logic [7:0]      sigma_t;
    logic [7:0]      e_num;
    logic [7:0]      e_den;
    logic [7:0]      e_div;
    logic [7:0]      div_val;
    logic            unused_even_sigma;

    // Sigma'(x) over GF(2) keeps only the odd-degree terms.
    assign sig_odd = {Sigma7, Sigma5, Sigma3, Sigma1};
    assign unused_even_sigma = ^{Sigma2, Sigma4, Sigma6, Sigma8};
    assign omega = {Omega7, Omega6, Omega5, Omega4, Omega3, Omega2, Omega1, Omega0};
    assign loc = {Location8, Location7, Location6, Location5,
                  Location4, Location3, Location2, Location1};
    assign {Value8, Value7, Value6, Value5, Value4, Value3, Value2, Value1} = val_q;
    assign nc_in = (NumErr > 4'd8) ? 4'd8 : NumErr;

    function automatic logic [7:0] mod255(input logic [11:0] x);
        logic [8:0] s;
        s = {1'b0, x[7:0]} + {5'b0, x[11:8]};
        s = {1'b0, s[7:0]} + {8'b0, s[8]};
        return (s[7:0] == 8'hFF) ? 8'h00 : s[7:0];
    endfunction

    // Log/antilog ROMs for x^8+x^4+x^3+x^2+1, folded to constants.
    always_comb begin
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 256; i++) log_rom[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            alog_rom[i] = x;
            if (i < 255) log_rom[x] = 8'(i);
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
    end

    always_comb begin
        j_k     = loc[k[2:0]];
        inv     = mod255(12'd255 - {4'h0, j_k});
        omega_t = omega[t];
        sigma_t = sig_odd[t[2:1]];
        e_num   = mod255({4'h0, log_rom[omega_t]} + {9'h0, t} * {4'h0, inv});
        e_den   = mod255({4'h0, sigma_t} + {9'h0, t[2:1], 1'b0} * {4'h0, inv});
        e_div   = mod255({4'h0, log_rom[num]} + (12'd255 - {4'h0, log_rom[den]}) + {4'h0, j_k});
        div_val = (num == 8'h00 || den == 8'h00) ? 8'h00 : alog_rom[e_div];
    end

`ifdef RS_FORNEY_FAIL_EN
    logic fail_q;
    logic loc_bad;

    always_comb begin
        loc_bad = 1'b0;
        for (int i = 0; i < 8; i++)
            if (4'(i) < nc_in && loc[i] == 8'hFF) loc_bad = 1'b1;
    end

    assign Fail = fail_q;
`else
    assign Fail = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            k     <= 4'd0;
            t     <= 3'd0;
            nc    <= 4'd0;
            num   <= 8'h00;
            den   <= 8'h00;
            val_q <= '0;
            Busy  <= 1'b0;
            Valid <= 1'b0;
`ifdef RS_FORNEY_FAIL_EN
            fail_q <= 1'b0;
`endif
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    k     <= 4'd0;
                    t     <= 3'd0;
                    num   <= 8'h00;
                    den   <= 8'h00;
                    nc    <= nc_in;
                    val_q <= '0;
                    Busy  <= 1'b1;
                    state <= (nc_in == 4'd0) ? DONE : ACC;
`ifdef RS_FORNEY_FAIL_EN
                    fail_q <= loc_bad;
`endif
                end
                ACC: begin
                    if (omega_t != 8'h00) num <= num ^ alog_rom[e_num];
                    if (t[0] && sigma_t != 8'hFF) den <= den ^ alog_rom[e_den];
                    t <= t + 3'd1;
                    if (t == 3'd7) state <= DIV;
                end
                DIV: begin
                    val_q[k[2:0]] <= div_val;
`ifdef RS_FORNEY_FAIL_EN
                    if (num != 8'h00 && den == 8'h00) fail_q <= 1'b1;
`endif
                    k     <= k + 4'd1;
                    num   <= 8'h00;
                    den   <= 8'h00;
                    state <= (k + 4'd1 == nc) ? DONE : ACC;
                end
                default: begin
                    Valid <= 1'b1;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_error_values.sv
// tb/tb_rs_error_values.sv - directed-vector self-checking bench for rs_error_values.
module tb_rs_error_values;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic            Start = 1'b1;
    logic [3:0]      NumErr = 4'd1;
    logic [7:0][7:0] sig;
    logic [7:0][7:0] om;
    logic [7:0][7:0] loc;
    logic [7:0][7:0] val;
    logic [7:0][7:0] e;
    logic            Busy;
    logic            Valid;
    logic            Fail;
    logic            busy_at1;
    logic            saw;
    int              lat;
    int              checks = 0;
    int              failures = 0;

`ifdef RS_FORNEY_FAIL_EN
    localparam logic FAIL_EN = 1'b1;
`else
    localparam logic FAIL_EN = 1'b0;
`endif

    rs_error_values dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .NumErr(NumErr),
        .Sigma1(sig[0]), .Sigma2(sig[1]), .Sigma3(sig[2]), .Sigma4(sig[3]),
        .Sigma5(sig[4]), .Sigma6(sig[5]), .Sigma7(sig[6]), .Sigma8(sig[7]),
        .Omega0(om[0]), .Omega1(om[1]), .Omega2(om[2]), .Omega3(om[3]),
        .Omega4(om[4]), .Omega5(om[5]), .Omega6(om[6]), .Omega7(om[7]),
        .Location1(loc[0]), .Location2(loc[1]), .Location3(loc[2]), .Location4(loc[3]),
        .Location5(loc[4]), .Location6(loc[5]), .Location7(loc[6]), .Location8(loc[7]),
        .Value1(val[0]), .Value2(val[1]), .Value3(val[2]), .Value4(val[3]),
        .Value5(val[4]), .Value6(val[5]), .Value7(val[6]), .Value8(val[7]),
        .Busy(Busy), .Valid(Valid), .Fail(Fail)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_vals(input string tag, input logic [7:0][7:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_value%0d", tag, i + 1), {24'h0, val[i]}, {24'h0, exp[i]});
    endtask

    task automatic clear_inputs();
        sig = {8{8'hFF}};
        om  = '0;
        loc = '0;
    endtask

    // Returns with the bench sitting 1 time unit after edge 0.
    task automatic launch(input logic [3:0] nerr);
        NumErr = nerr;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_valid(output int n_valid);
        n_valid = -1;
        busy_at1 = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clk);
            #1;
            if (n == 1) busy_at1 = Busy;
            if (Valid) begin
                n_valid = n;
                break;
            end
        end
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        saw = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge Clk);
            #1;
            saw = saw | Valid | Busy;
        end
        check(tag, {31'h0, saw}, 32'h0);
    endtask

    initial begin
        clear_inputs();

        // Reset held low with Start high
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", {31'h0, Busy}, 32'h0);
        check("rst_valid", {31'h0, Valid}, 32'h0);
        check("rst_fail", {31'h0, Fail}, 32'h0);
        check_vals("rst", '0);
        Reset = 1'b1;
        Start = 1'b0;
        idle_watch("rst_idle", 20);

        // Single error: e = Omega0
        clear_inputs();
        sig[0] = 8'h00;
        om[0]  = 8'h5A;
        launch(4'd1);
        wait_valid(lat);
        check("t1_lat", lat, 32'd10);
        check("t1_busy1", {31'h0, busy_at1}, 32'h1);
        check("t1_busy_end", {31'h0, Busy}, 32'h0);
        check("t1_fail", {31'h0, Fail}, 32'h0);
        e = '0;
        e[0] = 8'h5A;
        check_vals("t1", e);
        @(posedge Clk);
        #1;
        check("t1_valid_pulse", {31'h0, Valid}, 32'h0);
        check("t1_hold", {24'h0, val[0]}, 32'h5A);

        // NumErr=0 clears the previous result
        launch(4'd0);
        wait_valid(lat);
        check("t2_lat", lat, 32'd1);
        check_vals("t2", '0);

        // NumErr=12 clamps to 8; e_k = alpha^j_k
        clear_inputs();
        sig[0] = 8'h00;
        om[0]  = 8'h01;
        for (int i = 0; i < 8; i++) loc[i] = 8'(i);
        launch(4'd12);
        wait_valid(lat);
        check("t3_lat", lat, 32'd73);
        e = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        check_vals("t3", e);
        check("t3_fail", {31'h0, Fail}, 32'h0);

        // Omega = 1 + x: e = X + 1
        clear_inputs();
        sig[0] = 8'h00;
        om[0]  = 8'h01;
        om[1]  = 8'h01;
        loc[0] = 8'd1;
        loc[1] = 8'd8;
        loc[2] = 8'd9;
        launch(4'd3);
        wait_valid(lat);
        check("t4_lat", lat, 32'd28);
        e = '0;
        e[0] = 8'h03;
        e[1] = 8'h1C;
        e[2] = 8'h3B;
        check_vals("t4", e);

        // Sigma' = 1 + x^2, Omega = 3 + 3x^2: e = 3X
        clear_inputs();
        sig[0] = 8'h00;
        sig[2] = 8'h00;
        om[0]  = 8'h03;
        om[2]  = 8'h03;
        loc[0] = 8'd1;
        loc[1] = 8'd5;
        launch(4'd2);
        wait_valid(lat);
        check("t5_lat", lat, 32'd19);
        e = '0;
        e[0] = 8'h06;
        e[1] = 8'h60;
        check_vals("t5", e);
        check("t5_fail", {31'h0, Fail}, 32'h0);

        // Zero divisor: all odd Sigma are the zero element
        clear_inputs();
        om[0]  = 8'h01;
        loc[1] = 8'd1;
        launch(4'd2);
        wait_valid(lat);
        check("t6_lat", lat, 32'd19);
        check("t6_fail", {31'h0, Fail}, {31'h0, FAIL_EN});
        check_vals("t6", '0);

        // Back-to-back: Start during the Valid cycle
        clear_inputs();
        sig[0] = 8'h00;
        om[0]  = 8'h5A;
        launch(4'd1);
        wait_valid(lat);
        check("t7_lat_a", lat, 32'd10);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        wait_valid(lat);
        check("t7_lat_b", lat, 32'd10);
        check("t7_busy1", {31'h0, busy_at1}, 32'h1);
        check("t7_v1", {24'h0, val[0]}, 32'h5A);

        // Start ignored mid-run, then Reset at edge 20
        clear_inputs();
        sig[0] = 8'h00;
        om[0]  = 8'h01;
        for (int i = 0; i < 8; i++) loc[i] = 8'(i);
        launch(4'd8);
        repeat (4) @(posedge Clk);
        #1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (14) @(posedge Clk);
        #1;
        check("t8_busy19", {31'h0, Busy}, 32'h1);
        check("t8_v1_19", {24'h0, val[0]}, 32'h01);
        check("t8_v2_19", {24'h0, val[1]}, 32'h02);
        check("t8_v3_19", {24'h0, val[2]}, 32'h00);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("t8_rst_busy", {31'h0, Busy}, 32'h0);
        check("t8_rst_valid", {31'h0, Valid}, 32'h0);
        check("t8_rst_fail", {31'h0, Fail}, 32'h0);
        check_vals("t8_rst", '0);
        Reset = 1'b1;
        idle_watch("t8_idle", 10);
        launch(4'd8);
        wait_valid(lat);
        check("t8_lat", lat, 32'd73);
        e = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        check_vals("t8", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_error_values.md
# rs_error_values

Forney error-magnitude evaluator for the DVB-T RS(204,188) decoder (GF(256), primitive polynomial x^8+x^4+x^3+x^2+1, generator roots alpha^0..alpha^15, so b=0). It sits directly downstream of the Chien-search error-location stage. It consumes the error-locator polynomial, the error-evaluator polynomial Omega and up to 8 error locations. For each location it computes e_k = X_k * Omega(X_k^-1) / Sigma'(X_k^-1), one location at a time, and hands the 8 magnitudes to the byte corrector.

## Interface
Parameters: none.

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-low
- Start  in  1  single-cycle request; sampled only in IDLE
- NumErr  in  4  count of valid locations; values above 8 are clamped to 8
- Sigma1..Sigma8  in  8 each  locator coefficients in log form (0..254); 8'hFF encodes the zero element
- Omega0..Omega7  in  8 each  evaluator coefficients in polynomial form
- Location1..Location8  in  8 each  exponent j_k of X_k = alpha^j_k (0..254)
- Value1..Value8  out  8 each  error magnitudes in polynomial form; slots at or above NumErr read 0
- Busy  out  1  high from the cycle after Start until Valid
- Valid  out  1  one-cycle pulse; Value* are stable from this cycle until the next Start
- Fail  out  1  uncorrectable flag, valid with Valid (see Configuration)

## Operation
- Inputs must be held stable from Start until Valid.
- Log/antilog tables are 256-entry ROMs loaded at init.
- FSM: IDLE -> ACC -> DIV -> (ACC for next k | DONE) -> IDLE.
- IDLE:
  - Start=1 and NumErr=0: go to DONE.
  - Start=1 otherwise: k=0, t=0, num=0, den=0, latch Nc=min(NumErr,8), clear Value* and Fail.
- ACC runs 8 cycles, t=0..7, with inv = (255 - j_k) mod 255:
  - If Omega_t != 0: num ^= antilog((log Omega_t + t*inv) mod 255).
  - If t is odd and Sigma_t != 8'hFF: den ^= antilog((Sigma_t + (t-1)*inv) mod 255).
  - All mod-255 reductions use an explicit fold; intermediate width is 12 bits.
- DIV (1 cycle):
  - num=0: Value_k = 0.
  - den=0: zero-divisor event (see Configuration).
  - Otherwise: Value_k = antilog((log num - log den + j_k) mod 255).
  - Then k++, clear num/den. If k = Nc go to DONE, else go to ACC.
- DONE (1 cycle): Valid=1, Busy=0, go to IDLE.
- Start while not in IDLE is ignored.
- Reset low at any time: state IDLE, all Value*=0, Busy=0, Valid=0, Fail=0, k=t=0. Reset has priority over Start in the same cycle.

## Timing
- Reset values: every output is 0.
- Start sampled at edge 0. Busy is high from edge 1.
- Each location costs 9 cycles (8 ACC + 1 DIV).
- Valid is high in the cycle after edge 9*Nc+1.
  - Nc=0: Valid in the cycle after edge 1.
  - Nc=8: Valid in the cycle after edge 73.
- Value_k registers at the DIV edge of location k. Earlier slots can change before Valid; consumers read only on Valid.
- Back-to-back operation: Start may assert in the cycle Valid is high; it is accepted on the following edge, once the FSM is back in IDLE.

## Configuration
- `RS_FORNEY_FAIL_EN` defined:
  - A DIV with den=0 sets Fail (sticky until the next Start) and writes Value_k=0.
  - Fail also sets if any j_k for k<Nc equals 8'hFF.
- `RS_FORNEY_FAIL_EN` undefined:
  - Fail is tied to 0.
  - den=0 gives Value_k=0 silently.
  - Locations are not range-checked.

## Test plan
- Reset held low 3 cycles with Start=1 -> Busy, Valid, Fail, Value* all 0; no Valid after release until a new Start.
- Single error: NumErr=1, Location1=0, Sigma1=0, Sigma2..8=8'hFF, Omega0=8'h5A, Omega1..7=0, Start -> Valid in the cycle after edge 10, Value1=8'h5A, Value2..8=0, Fail=0.
- NumErr=0 with Start -> Valid one cycle after edge 1, all Value*=0; NumErr=12 -> treated as 8, Valid after edge 73.
- Sigma1=Sigma3=Sigma5=Sigma7=8'hFF, NumErr=2, Omega0=8'h01 -> with the macro: Fail=1 and Value1=Value2=0; without the macro: Fail=0 and Value1=Value2=0.
- Start pulsed again at edge 5 of a busy run, then Reset asserted at edge 20 -> second Start ignored; after Reset all outputs 0 and FSM in IDLE; a fresh Start completes normally.
- Random 1..8-error codewords from the golden model, run with the Chien-search stage upstream -> Value* match the model, and XOR correction restores the transmitted codeword for 1000 seeds.
